// File: rtl/shift_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface : shift_arbiter_if                                           |
// | Purpose   : Bundles the two request ports (A, B) and the response port |
// |             of shift_arbiter.                                          |
// | Modports  : master - request/response side (drives requests,          |
// |                      rsp_ready; observes readies and the response)     |
// |             slave  - the arbiter itself                                |
// | Signals   : a_valid/a_ready/a_in/a_cnt/a_op/a_btr   port A request     |
// |             b_valid/b_ready/b_in/b_cnt/b_op/b_btr   port B request     |
// |             rsp_valid/rsp_ready/rsp_id/rsp_data     held result        |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
interface shift_arbiter_if #(
  parameter int N = 16,
  parameter int C = 4,
  parameter int O = 2
);
  logic         a_valid;
  logic         a_ready;
  logic [N-1:0] a_in;
  logic [C-1:0] a_cnt;
  logic [O-1:0] a_op;
  logic         a_btr;

  logic         b_valid;
  logic         b_ready;
  logic [N-1:0] b_in;
  logic [C-1:0] b_cnt;
  logic [O-1:0] b_op;
  logic         b_btr;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [N-1:0] rsp_data;

  modport master (
    output a_valid, a_in, a_cnt, a_op, a_btr,
    input  a_ready,
    output b_valid, b_in, b_cnt, b_op, b_btr,
    input  b_ready,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready
  );

  modport slave (
    input  a_valid, a_in, a_cnt, a_op, a_btr,
    output a_ready,
    input  b_valid, b_in, b_cnt, b_op, b_btr,
    output b_ready,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready
  );
endinterface
`default_nettype wire

// File: rtl/shift_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : shift_arbiter_barrel                                       |
// | Purpose   : Combinational barrel shifter. Rotate/shift left, rotate/   |
// |             shift right, or full bit reversal.                         |
// | Ports     : i_in  N-bit operand        i_cnt C-bit shift count         |
// |             i_op  O-bit opcode         i_btr bit-reverse select        |
// |             o_out N-bit result                                         |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
module shift_arbiter_barrel #(
  parameter int N = 16,
  parameter int C = 4,
  parameter int O = 2
) (
  input  wire logic [N-1:0] i_in,
  input  wire logic [C-1:0] i_cnt,
  input  wire logic [O-1:0] i_op,
  input  wire logic         i_btr,
  output logic      [N-1:0] o_out
);
  localparam int c_stg = (N > 1) ? $clog2(N) : 1;

  localparam logic [O-1:0] c_op_rol = O'(0);
  localparam logic [O-1:0] c_op_sll = O'(1);
  localparam logic [O-1:0] c_op_ror = O'(2);
  localparam logic [O-1:0] c_op_srl = O'(3);

  logic [c_stg-1:0] w_amt;
  logic             w_right;
  logic             w_rot;
  logic [N-1:0]     w_rev_in;
  logic [N-1:0]     w_pre;
  logic [N-1:0]     w_left_res;
  logic [N-1:0]     w_rev_res;

  // Count is reduced modulo the data width; the remainder always fits the
  // stage count because it is strictly less than N.
  assign w_amt = c_stg'(32'(i_cnt) % N);

  always_comb begin
    w_right = 1'b0;
    w_rot   = 1'b1;
    case (i_op)
      c_op_rol: begin w_right = 1'b0; w_rot = 1'b1; end
      c_op_sll: begin w_right = 1'b0; w_rot = 1'b0; end
      c_op_ror: begin w_right = 1'b1; w_rot = 1'b1; end
      c_op_srl: begin w_right = 1'b1; w_rot = 1'b0; end
      default:  begin w_right = 1'b0; w_rot = 1'b1; end
    endcase
  end

  // Right-direction operations reuse the left-shifting network by
  // reversing the operand on the way in and the result on the way out.
  for (genvar i = 0; i < N; i++) begin : g_rev
    assign w_rev_in[i]  = i_in[N-1-i];
    assign w_rev_res[i] = w_left_res[N-1-i];
  end

  assign w_pre = w_right ? w_rev_in : i_in;

  // Stage s moves the word left by 2**s when bit s of the amount is set;
  // rotations wrap the bits that leave the top, logical shifts fill zeros.
  for (genvar s = 0; s < c_stg; s++) begin : g_stage
    localparam int c_sh = 1 << s;
    logic [N-1:0] w_prev;
    logic [N-1:0] w_moved;
    logic [N-1:0] w_out;

    if (s == 0) begin : g_first
      assign w_prev = w_pre;
    end else begin : g_next
      assign w_prev = g_stage[s-1].w_out;
    end

    assign w_moved = w_rot ? {w_prev[N-1-c_sh:0], w_prev[N-1 -: c_sh]}
                           : {w_prev[N-1-c_sh:0], {c_sh{1'b0}}};
    assign w_out   = w_amt[s] ? w_moved : w_prev;
  end

  assign w_left_res = g_stage[c_stg-1].w_out;

  assign o_out = i_btr   ? w_rev_in  :
                 w_right ? w_rev_res : w_left_res;
endmodule

// +------------------------------------------------------------------------+
// | Module    : shift_arbiter                                              |
// | Purpose   : Round-robin arbiter placing two requesters (A, B) on one   |
// |             shared barrel shifter, with a single registered result     |
// |             slot and valid/ready handshakes on every port.             |
// | Ports     : clk  rising-edge clock                                     |
// |             rst  asynchronous active-low reset                         |
// |             bus  shift_arbiter_if.slave (requests A/B, response)       |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
module shift_arbiter #(
  parameter int N = 16,
  parameter int C = 4,
  parameter int O = 2
) (
  input wire logic      clk,
  input wire logic      rst,
  shift_arbiter_if.slave bus
);
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_ptr;        // 0: A favoured on contention, 1: B favoured
  logic         r_id;
  logic [N-1:0] r_data;

  logic         w_gnt_a;
  logic         w_gnt_b;
  logic         w_open;
  logic         w_acc;
  logic [N-1:0] w_sh_in;
  logic [C-1:0] w_sh_cnt;
  logic [O-1:0] w_sh_op;
  logic         w_sh_btr;
  logic [N-1:0] w_sh_out;

  // Grant is a pure function of the two valids and the priority pointer.
  assign w_gnt_a = bus.a_valid & (~bus.b_valid | ~r_ptr);
  assign w_gnt_b = bus.b_valid & (~bus.a_valid |  r_ptr);

  // The result slot can take a new value when empty, or when the current
  // value leaves on this same edge. Gated by rst so both readies stay low
  // throughout reset.
  assign w_open = rst & ((r_state == IDLE) | bus.rsp_ready);

  assign bus.a_ready = w_gnt_a & w_open;
  assign bus.b_ready = w_gnt_b & w_open;
  assign w_acc       = (w_gnt_a | w_gnt_b) & w_open;

  // Operand mux in front of the single shared shifter.
  assign w_sh_in  = w_gnt_b ? bus.b_in  : bus.a_in;
  assign w_sh_cnt = w_gnt_b ? bus.b_cnt : bus.a_cnt;
  assign w_sh_op  = w_gnt_b ? bus.b_op  : bus.a_op;
  assign w_sh_btr = w_gnt_b ? bus.b_btr : bus.a_btr;

  shift_arbiter_barrel #(
    .N (N),
    .C (C),
    .O (O)
  ) u_barrel (
    .i_in  (w_sh_in),
    .i_cnt (w_sh_cnt),
    .i_op  (w_sh_op),
    .i_btr (w_sh_btr),
    .o_out (w_sh_out)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_acc) w_state_nxt = HOLD;
      end
      HOLD: begin
        // An acceptance in HOLD implies rsp_ready, so the slot is refilled.
        if (bus.rsp_ready && !w_acc) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
      r_id    <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc) begin
        r_data <= w_sh_out;
        r_id   <= w_gnt_b;
        // Point away from the port just served.
        r_ptr  <= w_gnt_a;
      end
    end
  end

  assign bus.rsp_valid = (r_state == HOLD);
  assign bus.rsp_id    = r_id;
  assign bus.rsp_data  = r_data;
endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : tb_shift_arbiter                                           |
// | Purpose   : Self-checking bench for shift_arbiter: directed scenarios   |
// |             plus randomized traffic against a behavioural model.       |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
module tb_shift_arbiter;
  localparam int N = 16;
  localparam int C = 4;
  localparam int O = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shift_arbiter_if #(.N(N), .C(C), .O(O)) bus ();

  shift_arbiter #(.N(N), .C(C), .O(O)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model of the arbiter: priority, occupancy and held result.
  logic         m_ptr;   // 1 means B wins the next contention
  logic         m_full;
  logic [N-1:0] m_data;
  logic         m_id;

  // Reference shifter written bit by bit from the opcode definitions.
  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] x,
                                             input logic [C-1:0] cnt,
                                             input logic [O-1:0] op,
                                             input logic btr);
    logic [N-1:0] r;
    int k;
    r = '0;
    k = int'(cnt) % N;
    for (int i = 0; i < N; i++) begin
      if (btr)               r[i] = x[N-1-i];
      else if (op == 2'd0)   r[i] = x[(i - k + N) % N];
      else if (op == 2'd1)   r[i] = (i >= k) ? x[i-k] : 1'b0;
      else if (op == 2'd2)   r[i] = x[(i + k) % N];
      else                   r[i] = (i + k < N) ? x[i+k] : 1'b0;
    end
    return r;
  endfunction

  function automatic logic exp_a_ready();
    return rst && bus.a_valid && (!bus.b_valid || !m_ptr) && (!m_full || bus.rsp_ready);
  endfunction

  function automatic logic exp_b_ready();
    return rst && bus.b_valid && (!bus.a_valid || m_ptr) && (!m_full || bus.rsp_ready);
  endfunction

  task automatic model_reset();
    m_ptr  = 1'b0;
    m_full = 1'b0;
    m_data = '0;
    m_id   = 1'b0;
  endtask

  // Advance one clock edge and move the model along with it.
  task automatic tick();
    logic ga, gb;
    logic [N-1:0] d;
    ga = exp_a_ready();
    gb = exp_b_ready();
    d  = gb ? ref_shift(bus.b_in, bus.b_cnt, bus.b_op, bus.b_btr)
            : ref_shift(bus.a_in, bus.a_cnt, bus.a_op, bus.a_btr);
    @(posedge clk);
    #1;
    if (ga || gb) begin
      m_full = 1'b1;
      m_data = d;
      m_id   = gb;
      m_ptr  = ga;
    end else if (m_full && bus.rsp_ready && rst) begin
      m_full = 1'b0;
    end
  endtask

  task automatic drive_a(input logic v, input logic [N-1:0] d, input logic [C-1:0] c,
                         input logic [O-1:0] o, input logic b);
    bus.a_valid = v; bus.a_in = d; bus.a_cnt = c; bus.a_op = o; bus.a_btr = b;
  endtask

  task automatic drive_b(input logic v, input logic [N-1:0] d, input logic [C-1:0] c,
                         input logic [O-1:0] o, input logic b);
    bus.b_valid = v; bus.b_in = d; bus.b_cnt = c; bus.b_op = o; bus.b_btr = b;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_a(1'b1, 16'h1234, 4'd3, 2'd0, 1'b0);
    drive_b(1'b1, 16'h4321, 4'd5, 2'd1, 1'b0);
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_data !== 16'h0000) begin n_bad++; $display("FAIL reset_rsp_data: got %h want 0000", bus.rsp_data); end
    n_cmp++; if (bus.rsp_id !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_id: got %b want 0", bus.rsp_id); end
    n_cmp++; if (bus.a_ready !== 1'b0) begin n_bad++; $display("FAIL reset_a_ready: got %b want 0", bus.a_ready); end
    n_cmp++; if (bus.b_ready !== 1'b0) begin n_bad++; $display("FAIL reset_b_ready: got %b want 0", bus.b_ready); end
    drive_a(1'b0, '0, '0, '0, 1'b0);
    drive_b(1'b0, '0, '0, '0, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_single_then_reset();
    drive_a(1'b1, 16'h8001, 4'd1, 2'b00, 1'b0);
    bus.rsp_ready = 1'b0;
    #1;
    n_cmp++; if (bus.a_ready !== 1'b1) begin n_bad++; $display("FAIL single_a_ready: got %b want 1", bus.a_ready); end
    tick();
    n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL single_rsp_valid: got %b want 1", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_data !== 16'h0003) begin n_bad++; $display("FAIL single_rsp_data: got %h want 0003", bus.rsp_data); end
    n_cmp++; if (bus.rsp_id !== 1'b0) begin n_bad++; $display("FAIL single_rsp_id: got %b want 0", bus.rsp_id); end
    drive_a(1'b0, '0, '0, '0, 1'b0);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_reset_valid: got %b want 0", bus.rsp_valid); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_contention();
    logic [N-1:0] ad;
    ad = N'($urandom);
    drive_a(1'b1, ad, C'($urandom), O'($urandom), 1'b0);
    drive_b(1'b1, 16'h8000, 4'd15, 2'b11, 1'b0);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.a_ready !== (i != 1)) begin n_bad++; $display("FAIL contention_a_ready[%0d]: got %b want %b", i, bus.a_ready, (i != 1)); end
      n_cmp++; if (bus.b_ready !== (i == 1)) begin n_bad++; $display("FAIL contention_b_ready[%0d]: got %b want %b", i, bus.b_ready, (i == 1)); end
      tick();
      n_cmp++; if (bus.rsp_id !== (i == 1)) begin n_bad++; $display("FAIL contention_id[%0d]: got %b want %b", i, bus.rsp_id, (i == 1)); end
      if (i == 1) begin
        n_cmp++; if (bus.rsp_data !== 16'h0001) begin n_bad++; $display("FAIL contention_b_data: got %h want 0001", bus.rsp_data); end
      end else begin
        n_cmp++; if (bus.rsp_data !== m_data) begin n_bad++; $display("FAIL contention_a_data[%0d]: got %h want %h", i, bus.rsp_data, m_data); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] hold_d;
    logic         hold_id;
    logic [N-1:0] bd;
    hold_d  = m_data;
    hold_id = m_id;
    bd = N'($urandom);
    drive_a(1'b0, '0, '0, '0, 1'b0);
    drive_b(1'b1, bd, 4'd7, 2'b10, 1'b0);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.b_ready !== 1'b0) begin n_bad++; $display("FAIL bp_b_ready[%0d]: got %b want 0", i, bus.b_ready); end
      tick();
      n_cmp++; if (bus.rsp_data !== hold_d || bus.rsp_id !== hold_id || bus.rsp_valid !== 1'b1)
        begin n_bad++; $display("FAIL bp_hold[%0d]: got %h/%b/%b want %h/%b/1", i, bus.rsp_data, bus.rsp_id, bus.rsp_valid, hold_d, hold_id); end
    end
    bus.rsp_ready = 1'b1;
    #1;
    n_cmp++; if (bus.b_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_b_ready: got %b want 1", bus.b_ready); end
    tick();
    n_cmp++; if (bus.rsp_id !== 1'b1) begin n_bad++; $display("FAIL bp_release_id: got %b want 1", bus.rsp_id); end
    n_cmp++; if (bus.rsp_data !== ref_shift(bd, 4'd7, 2'b10, 1'b0)) begin n_bad++; $display("FAIL bp_release_data: got %h want %h", bus.rsp_data, ref_shift(bd, 4'd7, 2'b10, 1'b0)); end
    drive_b(1'b0, '0, '0, '0, 1'b0);
    tick();
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain_valid: got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_bitrev();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 16'h0001, C'($urandom), O'($urandom), 1'b1);
      tick();
      n_cmp++; if (bus.rsp_data !== 16'h8000) begin n_bad++; $display("FAIL bitrev[%0d]: got %h want 8000", i, bus.rsp_data); end
    end
    drive_a(1'b0, '0, '0, '0, 1'b0);
    tick();
  endtask

  task automatic test_sll_edge();
    bus.rsp_ready = 1'b1;
    drive_a(1'b1, 16'hA5A5, 4'd0, 2'b01, 1'b0);
    tick();
    n_cmp++; if (bus.rsp_data !== 16'hA5A5) begin n_bad++; $display("FAIL sll_cnt0: got %h want a5a5", bus.rsp_data); end
    drive_a(1'b1, 16'hA5A5, 4'd4, 2'b01, 1'b0);
    tick();
    n_cmp++; if (bus.rsp_data !== 16'h5A50) begin n_bad++; $display("FAIL sll_cnt4: got %h want 5a50", bus.rsp_data); end
    drive_a(1'b0, '0, '0, '0, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    logic e_id;
    logic prev_id;
    bus.rsp_ready = 1'b1;
    prev_id = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_a(1'b1, N'($urandom), C'($urandom), O'($urandom), 1'b0);
      drive_b(1'b1, N'($urandom), C'($urandom), O'($urandom), 1'b0);
      e_id = m_ptr;
      tick();
      n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== e_id || bus.rsp_data !== m_data)
        begin n_bad++; $display("FAIL b2b[%0d]: got %b/%b/%h want 1/%b/%h", i, bus.rsp_valid, bus.rsp_id, bus.rsp_data, e_id, m_data); end
      if (i > 0) begin
        n_cmp++; if (bus.rsp_id === prev_id) begin n_bad++; $display("FAIL b2b_alternate[%0d]: got %b want %b", i, bus.rsp_id, !prev_id); end
      end
      prev_id = bus.rsp_id;
    end
    drive_a(1'b0, '0, '0, '0, 1'b0);
    drive_b(1'b0, '0, '0, '0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_hold();
    logic [N-1:0] ad;
    bus.rsp_ready = 1'b0;
    drive_a(1'b1, 16'h00F0, 4'd2, 2'b00, 1'b0);
    tick();
    drive_a(1'b0, '0, '0, '0, 1'b0);
    @(posedge clk);
    #2;
    n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL midhold_pre_valid: got %b want 1", bus.rsp_valid); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL midhold_valid: got %b want 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_data !== 16'h0000) begin n_bad++; $display("FAIL midhold_data: got %h want 0000", bus.rsp_data); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    tick();
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL midhold_stale: got %b want 0", bus.rsp_valid); end
    ad = N'($urandom);
    drive_a(1'b1, ad, 4'd9, 2'b10, 1'b0);
    tick();
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== ref_shift(ad, 4'd9, 2'b10, 1'b0))
      begin n_bad++; $display("FAIL midhold_resume: got %b/%h want 1/%h", bus.rsp_valid, bus.rsp_data, ref_shift(ad, 4'd9, 2'b10, 1'b0)); end
    drive_a(1'b0, '0, '0, '0, 1'b0);
    bus.rsp_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic took_a, took_b;
    took_a = 1'b1;
    took_b = 1'b1;
    for (int i = 0; i < 400; i++) begin
      // A pending request that was not taken is held unchanged.
      if (took_a || !bus.a_valid)
        drive_a(($urandom_range(0, 3) != 0), N'($urandom), C'($urandom), O'($urandom), ($urandom_range(0, 7) == 0));
      if (took_b || !bus.b_valid)
        drive_b(($urandom_range(0, 3) != 0), N'($urandom), C'($urandom), O'($urandom), ($urandom_range(0, 7) == 0));
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      took_a = exp_a_ready();
      took_b = exp_b_ready();
      n_cmp++; if (bus.a_ready !== took_a || bus.b_ready !== took_b)
        begin n_bad++; $display("FAIL rand_ready[%0d]: got %b%b want %b%b", i, bus.a_ready, bus.b_ready, took_a, took_b); end
      tick();
      n_cmp++; if (bus.rsp_valid !== m_full) begin n_bad++; $display("FAIL rand_valid[%0d]: got %b want %b", i, bus.rsp_valid, m_full); end
      if (m_full) begin
        n_cmp++; if (bus.rsp_data !== m_data || bus.rsp_id !== m_id)
          begin n_bad++; $display("FAIL rand_rsp[%0d]: got %h/%b want %h/%b", i, bus.rsp_data, bus.rsp_id, m_data, m_id); end
      end
    end
  endtask

  initial begin
    drive_a(1'b0, '0, '0, '0, 1'b0);
    drive_b(1'b0, '0, '0, '0, 1'b0);
    bus.rsp_ready = 1'b0;
    model_reset();
    test_reset();
    test_single_then_reset();
    test_contention();
    test_backpressure();
    test_bitrev();
    test_sll_edge();
    test_back_to_back();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
